// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; owns the fetch PC, issues one word request at a time, buffers responses for decode.
// Latency: a granted word is pushed the cycle its rvalid arrives; it is visible at inst/inst_pc the next cycle.
// Backpressure: no request is issued while the buffer plus the in-flight word would overflow; a redirect flushes the buffer.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   branch_taken, branch_target   one-cycle redirect from the execute-stage branch unit
//   imem_req/addr/gnt             request handshake toward instruction memory (req & gnt = accepted)
//   imem_rvalid/rdata             response, earliest one cycle after the grant
//   inst_valid/ready, inst/pc     buffer head toward decode (valid & ready = pop)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Buffer storage: no reset needed, validity is tracked by count_q.
    logic [31:0]      pc_buf_q   [FIFO_DEPTH];
    logic [31:0]      inst_buf_q [FIFO_DEPTH];

    logic grant;
    logic resp;
    logic push;
    logic pop;
    logic room;

    // Only the word-aligned part of the target is used.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];

    // The in-flight word reserves a slot, so a push can never find the buffer full.
    assign room      = ((CNT_W+1)'(count_q) + (CNT_W+1)'(outstanding_q)) < (CNT_W+1)'(FIFO_DEPTH);
    assign imem_req  = !rst && !outstanding_q && room;
    assign imem_addr = fetch_pc_q;

    assign grant = imem_req && imem_gnt;
    assign resp  = imem_rvalid && outstanding_q;
    assign push  = resp && !drop_q && !branch_taken;
    assign pop   = inst_valid && inst_ready && !branch_taken;

    assign inst_valid = !rst && (count_q != '0);
    assign inst       = inst_buf_q[rd_ptr_q];
    assign inst_pc    = pc_buf_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (grant) begin
            req_pc_d = fetch_pc_q;
        end

        if (branch_taken) begin
            fetch_pc_d = {branch_target[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A word still owed by memory (including one granted right now) is wrong-path.
            // A response landing in this very cycle is simply not pushed and needs no drop.
            outstanding_d = (outstanding_q && !resp) || grant;
            drop_d        = (outstanding_q && !resp) || grant;
        end else begin
            if (grant) begin
                outstanding_d = 1'b1;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (resp) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_buf_q[wr_ptr_q]   <= req_pc_q;
            inst_buf_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed bench for fetch_unit with a one-cycle-latency instruction memory model.
// Latency: memory answers one cycle after each grant unless mem_en holds the response back.
// Backpressure: inst_ready and imem_gnt are driven directly by the stimulus.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    // Memory model: each word's content is a fixed scramble of its address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        mem_en;
    logic        gnt_en;

    assign imem_gnt    = gnt_en;
    assign imem_rvalid = pend && mem_en;
    assign imem_rdata  = imem_rvalid ? word_of(pend_addr) : 32'h0;

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic look(input string tag, input logic req, input logic [31:0] addr,
                        input logic vld, input logic [31:0] pc);
        chk({tag, ".req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, ".addr"}, imem_addr, addr);
        chk({tag, ".valid"}, 32'(inst_valid), 32'(vld));
        if (vld) begin
            chk({tag, ".pc"}, inst_pc, pc);
            chk({tag, ".inst"}, inst, word_of(pc));
        end
    endtask

    typedef struct {
        logic        r;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t v;
        v.r = r; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        vecs.push_back(v);
    endfunction

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        inst_ready = 1'b1; mem_en = 1'b1; gnt_en = 1'b1;

        // T1: reset then zero-wait streaming, one instruction per two cycles
        add(1, 1, 0, 0,     0, 0);
        add(1, 1, 0, 0,     0, 0);
        add(0, 1, 1, 'h100, 0, 0);
        add(0, 1, 0, 0,     0, 0);
        add(0, 1, 1, 'h104, 1, 'h100);
        add(0, 1, 0, 0,     0, 0);
        add(0, 1, 1, 'h108, 1, 'h104);
        add(0, 1, 0, 0,     0, 0);
        add(0, 1, 1, 'h10C, 1, 'h108);
        // T2: decode stalled, buffer fills to 4 and requests stop; then drain
        add(1, 0, 0, 0,     0, 0);
        add(0, 0, 1, 'h100, 0, 0);
        add(0, 0, 0, 0,     0, 0);
        add(0, 0, 1, 'h104, 1, 'h100);
        add(0, 0, 0, 0,     1, 'h100);
        add(0, 0, 1, 'h108, 1, 'h100);
        add(0, 0, 0, 0,     1, 'h100);
        add(0, 0, 1, 'h10C, 1, 'h100);
        add(0, 0, 0, 0,     1, 'h100);
        add(0, 0, 0, 0,     1, 'h100);
        add(0, 0, 0, 0,     1, 'h100);
        add(0, 1, 0, 0,     1, 'h100);
        add(0, 1, 1, 'h110, 1, 'h104);
        add(0, 1, 0, 0,     1, 'h108);
        add(0, 1, 1, 'h114, 1, 'h10C);
        add(0, 1, 0, 0,     1, 'h110);
        add(0, 1, 1, 'h118, 1, 'h114);

        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].r;
            inst_ready = vecs[i].rdy;
            #1;
            look($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].pc);
            @(negedge clk);
        end

        // T3: redirect while 0x108 is in flight and two entries are buffered
        rst = 1'b1; inst_ready = 1'b0;
        nxt(); rst = 1'b0;
        repeat (4) nxt();
        look("t3.pre", 1, 'h108, 1, 'h100);
        nxt(); mem_en = 1'b0; branch_taken = 1'b1; branch_target = 32'h2000; #1;
        look("t3.redir", 0, 0, 1, 'h100);
        nxt(); branch_taken = 1'b0; mem_en = 1'b1; #1;
        look("t3.flush", 0, 0, 0, 0);
        nxt(); look("t3.req", 1, 'h2000, 0, 0); inst_ready = 1'b1;
        nxt(); look("t3.wait", 0, 0, 0, 0);
        nxt(); look("t3.first", 1, 'h2004, 1, 'h2000);

        // T4a: redirect in the same cycle as a grant (and a pop)
        branch_taken = 1'b1; branch_target = 32'h3000;
        nxt(); branch_taken = 1'b0; look("t4a.flush", 0, 0, 0, 0);
        nxt(); look("t4a.req", 1, 'h3000, 0, 0);
        nxt(); look("t4a.wait", 0, 0, 0, 0); inst_ready = 1'b0;
        nxt(); look("t4a.first", 1, 'h3004, 1, 'h3000);

        // T4b: redirect in a cycle with a response push and a pop
        nxt(); inst_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h4000; #1;
        look("t4b.pushpop", 0, 0, 1, 'h3000);
        nxt(); branch_taken = 1'b0; look("t4b.flush", 1, 'h4000, 0, 0);
        nxt(); look("t4b.wait", 0, 0, 0, 0);
        nxt(); look("t4b.first", 1, 'h4004, 1, 'h4000);

        // T5: misaligned redirect at the top of the address space, then wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        nxt(); branch_taken = 1'b0; look("t5.flush", 0, 0, 0, 0);
        nxt(); look("t5.req", 1, 32'hFFFF_FFFC, 0, 0);
        nxt(); look("t5.wait", 0, 0, 0, 0);
        nxt(); look("t5.wrap", 1, 32'h0, 1, 32'hFFFF_FFFC);
        nxt(); look("t5.wait2", 0, 0, 0, 0);
        nxt(); look("t5.zero", 1, 32'h4, 1, 32'h0);

        // T6: reset with one word in flight and three buffered; late response must be ignored
        rst = 1'b1; inst_ready = 1'b0;
        nxt(); rst = 1'b0;
        repeat (7) nxt();
        look("t6.pre", 0, 0, 1, 'h100);
        mem_en = 1'b0; rst = 1'b1; #1;
        look("t6.inrst", 0, 0, 0, 0);
        nxt(); rst = 1'b0; gnt_en = 1'b0; mem_en = 1'b1; #1;
        chk("t6.stray_rvalid_seen", 32'(imem_rvalid), 32'h1);
        look("t6.post", 1, RPC, 0, 0);
        nxt(); look("t6.ignored", 1, RPC, 0, 0); gnt_en = 1'b1;
        nxt(); look("t6.wait", 0, 0, 0, 0);
        nxt(); look("t6.first", 1, RPC + 32'h4, 1, RPC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
